// File: rtl/mpsoc3d_bb_ext_pkg.sv
// ---------------------------------------------------------------------------
// mpsoc3d_bb_ext_pkg
// Shared definitions for the Blackbone external-port arbiter.
//   BB_AW / BB_DW / BB_WEW : default address, data and byte-enable widths
//   bb_req_t               : one requester's fields {en, we, addr, din}, used
//                            to unflatten the packed request vectors
//   bb_is_read()           : an all-zero byte-enable field marks a read
// ---------------------------------------------------------------------------
package mpsoc3d_bb_ext_pkg;

    localparam int BB_AW  = 16;
    localparam int BB_DW  = 16;
    localparam int BB_WEW = BB_DW / 8;

    typedef struct packed {
        logic              en;
        logic [BB_WEW-1:0] we;
        logic [BB_AW-1:0]  addr;
        logic [BB_DW-1:0]  din;
    } bb_req_t;

    function automatic logic bb_is_read(input logic [BB_WEW-1:0] we);
        return (we == '0);
    endfunction

endpackage

// File: rtl/mpsoc3d_rr_arbiter.sv
// ---------------------------------------------------------------------------
// mpsoc3d_rr_arbiter
// Rotating-priority one-hot arbiter with its own pointer register. Search
// starts at (ptr+1) mod N and wraps; the first requesting index wins and
// becomes the new pointer. The grant is combinational from req_i.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset (ptr -> N-1)
//   req_i  [N] : eligible requests (caller applies any masking)
//   gnt_o  [N] : one-hot grant, all-zero when nothing requests
// ---------------------------------------------------------------------------
module mpsoc3d_rr_arbiter #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req_i,
    output logic [N-1:0] gnt_o
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;
    logic          found;
    int            idx;

    // NOTE: every signal written here gets a default first, so no path
    // through the loop can leave one unassigned and infer a latch.
    always_comb begin
        gnt_o = '0;
        ptr_d = ptr_q;
        found = 1'b0;
        idx   = 0;
        for (int off = 1; off <= N; off++) begin
            idx = (int'(ptr_q) + off) % N;
            if (!found && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                ptr_d      = PW'(idx);
                found      = 1'b1;
            end
        end
    end

    // Reset to N-1 so requester 0 is first in line after reset.
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= PW'(N - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/mpsoc3d_bb_ext_arbiter.sv
// ---------------------------------------------------------------------------
// mpsoc3d_bb_ext_arbiter
// Shares one Blackbone external memory port among NUM_REQ requesters with
// round-robin priority. One access per bus cycle; read data returns the
// cycle after issue and is steered back with a one-hot rvalid.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   req_en_i   [N]    : request valid, held stable until acked
//   req_we_i   [N*WEW]: byte write enables (all-zero = read)
//   req_addr_i [N*AW] : request address
//   req_din_i  [N*DW] : write data
//   req_ack_o  [N]    : one-hot, access on the bus this cycle
//   req_rvalid_o [N]  : one-hot, req_dout_o valid for that requester
//   req_dout_o [DW]   : shared read data (bb_ext_dout_i passed through)
//   bb_ext_*          : registered external bus strobe/enables/addr/data
// The request struct uses the package widths, so AW/DW follow BB_AW/BB_DW.
// ---------------------------------------------------------------------------
module mpsoc3d_bb_ext_arbiter
    import mpsoc3d_bb_ext_pkg::*;
#(
    parameter int NUM_REQ = 8,
    parameter int AW      = BB_AW,
    parameter int DW      = BB_DW,
    parameter int WEW     = DW / 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_en_i,
    input  logic [NUM_REQ*WEW-1:0] req_we_i,
    input  logic [NUM_REQ*AW-1:0]  req_addr_i,
    input  logic [NUM_REQ*DW-1:0]  req_din_i,
    output logic [NUM_REQ-1:0]     req_ack_o,
    output logic [NUM_REQ-1:0]     req_rvalid_o,
    output logic [DW-1:0]          req_dout_o,
    output logic                   bb_ext_en_o,
    output logic [WEW-1:0]         bb_ext_we_o,
    output logic [AW-1:0]          bb_ext_addr_o,
    output logic [DW-1:0]          bb_ext_din_o,
    input  logic [DW-1:0]          bb_ext_dout_i
);

    bb_req_t              reqs [NUM_REQ];
    bb_req_t              sel;
    logic [NUM_REQ-1:0]   eligible;
    logic [NUM_REQ-1:0]   gnt;
    logic                 any_gnt;

    logic                 bb_en_q,   bb_en_d;
    logic [WEW-1:0]       bb_we_q,   bb_we_d;
    logic [AW-1:0]        bb_addr_q, bb_addr_d;
    logic [DW-1:0]        bb_din_q,  bb_din_d;
    logic [NUM_REQ-1:0]   ack_q,     ack_d;
    logic [NUM_REQ-1:0]   rd_tag_q,  rd_tag_d;
    logic [NUM_REQ-1:0]   rvalid_q,  rvalid_d;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            reqs[i].en   = req_en_i[i];
            reqs[i].we   = req_we_i[i*WEW +: WEW];
            reqs[i].addr = req_addr_i[i*AW +: AW];
            reqs[i].din  = req_din_i[i*DW +: DW];
        end
    end

    // A requester still holds en during the cycle it sees its ack; masking
    // with the ack stops it from being granted the same access twice.
    assign eligible = req_en_i & ~ack_q;

    mpsoc3d_rr_arbiter #(
        .N (NUM_REQ)
    ) u_rr (
        .clk   (clk),
        .rst   (rst),
        .req_i (eligible),
        .gnt_o (gnt)
    );

    assign any_gnt = |gnt;

    // One-hot grant selects the winning request's fields.
    always_comb begin
        sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) sel = reqs[i];
        end
    end

    always_comb begin
        bb_en_d   = any_gnt;
        bb_we_d   = any_gnt ? sel.we : '0;
        bb_addr_d = any_gnt ? sel.addr : bb_addr_q;
        bb_din_d  = any_gnt ? sel.din : bb_din_q;
        ack_d     = gnt;
        rd_tag_d  = (any_gnt && bb_is_read(sel.we)) ? gnt : '0;
        // rvalid lines up with the cycle the memory drives its read data.
        rvalid_d  = rd_tag_q;
    end

    // Clearing rd_tag on reset guarantees an in-flight read never returns.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bb_en_q   <= 1'b0;
            bb_we_q   <= '0;
            bb_addr_q <= '0;
            bb_din_q  <= '0;
            ack_q     <= '0;
            rd_tag_q  <= '0;
            rvalid_q  <= '0;
        end else begin
            bb_en_q   <= bb_en_d;
            bb_we_q   <= bb_we_d;
            bb_addr_q <= bb_addr_d;
            bb_din_q  <= bb_din_d;
            ack_q     <= ack_d;
            rd_tag_q  <= rd_tag_d;
            rvalid_q  <= rvalid_d;
        end
    end

    assign bb_ext_en_o   = bb_en_q;
    assign bb_ext_we_o   = bb_we_q;
    assign bb_ext_addr_o = bb_addr_q;
    assign bb_ext_din_o  = bb_din_q;
    assign req_ack_o     = ack_q;
    assign req_rvalid_o  = rvalid_q;
    assign req_dout_o    = bb_ext_dout_i;

endmodule
